// File: rtl/encoder_capture.sv
// encoder_capture: quadrature encoder front-end.
// Two-flop synchronisers and stable-count glitch filters feed an x4 decoder
// that maintains a wrapping signed position count. A fixed gate window
// measures signed counts per window. A one-cycle clear from the register
// slave zeroes position, window state and the error flag.
module encoder_capture #(
  parameter int GATE_CYCLES = 50000,
  parameter int FILT_LEN    = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enc_a,
  input  logic               enc_b,
  input  logic               clear,
  output logic signed [31:0] step,
  output logic signed [31:0] speed,
  output logic               speed_valid,
  output logic               dir,
  output logic               err
);

  localparam int          GW        = $clog2(GATE_CYCLES);
  localparam logic [GW-1:0] GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [7:0]  CNT_LAST  = 8'(FILT_LEN - 1);

  // Channel bit 1 is A, bit 0 is B throughout.
  logic [1:0]        sync1_q, sync2_q;
  logic [1:0]        filt_q;
  logic [1:0][7:0]   cnt_q;
  logic [1:0]        prev_q;

  logic signed [31:0] step_q, speed_q, acc_q;
  logic [GW-1:0]      gate_q;
  logic               speed_valid_q, dir_q, err_q;

  logic [1:0]         diff_d;
  logic               up_d, dn_d, illegal_d;
  logic signed [31:0] delta_d;

  // Position of a Gray-coded {A,B} state around the forward cycle 00,10,11,01.
  function automatic logic [1:0] gray_pos(input logic [1:0] ab);
    case (ab)
      2'b00:   gray_pos = 2'd0;
      2'b10:   gray_pos = 2'd1;
      2'b11:   gray_pos = 2'd2;
      default: gray_pos = 2'd3;
    endcase
  endfunction

  // Synchronise raw pins and filter each channel independently.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      filt_q  <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {enc_a, enc_b};
      sync2_q <= sync1_q;
      for (int ch = 0; ch < 2; ch++) begin
        if (sync2_q[ch] == filt_q[ch]) begin
          cnt_q[ch] <= '0;
        end else if (cnt_q[ch] == CNT_LAST) begin
          filt_q[ch] <= sync2_q[ch];
          cnt_q[ch]  <= '0;
        end else begin
          cnt_q[ch] <= cnt_q[ch] + 8'd1;
        end
      end
    end
  end

  // Decode the step between previous and current filtered state.
  always_comb begin
    diff_d    = gray_pos(filt_q) - gray_pos(prev_q);
    up_d      = (diff_d == 2'd1);
    dn_d      = (diff_d == 2'd3);
    illegal_d = (diff_d == 2'd2);
    delta_d   = up_d ? 32'sd1 : (dn_d ? -32'sd1 : 32'sd0);
  end

  // Position, direction, error and gated speed; clear overrides counting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_q        <= '0;
      step_q        <= '0;
      speed_q       <= '0;
      acc_q         <= '0;
      gate_q        <= '0;
      speed_valid_q <= 1'b0;
      dir_q         <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      prev_q <= filt_q;
      if (clear) begin
        step_q        <= '0;
        acc_q         <= '0;
        gate_q        <= '0;
        err_q         <= 1'b0;
        speed_valid_q <= 1'b0;
      end else begin
        step_q <= step_q + delta_d;
        if (up_d || dn_d) dir_q <= up_d;
        if (illegal_d)    err_q <= 1'b1;
        if (gate_q == GATE_LAST) begin
          gate_q        <= '0;
          speed_q       <= acc_q + delta_d;
          acc_q         <= '0;
          speed_valid_q <= 1'b1;
        end else begin
          gate_q        <= gate_q + 1'b1;
          acc_q         <= acc_q + delta_d;
          speed_valid_q <= 1'b0;
        end
      end
    end
  end

  assign step        = step_q;
  assign speed       = speed_q;
  assign speed_valid = speed_valid_q;
  assign dir         = dir_q;
  assign err         = err_q;

endmodule

// File: doc/encoder_capture.md
Name: encoder_capture

Overview:
- Front-end for the incremental-encoder channel.
- Synchronises and glitch-filters the raw quadrature A/B pins, decodes them in x4 mode, and keeps a signed 32-bit position count (step).
- Measures signed counts per fixed gate window (speed).
- Sits directly upstream of the encoder register slave: drives its step/speed inputs and consumes its one-cycle clear pulse.

Parameters:
GATE_CYCLES, 50000, speed gate window length in clk cycles (1 ms at 50 MHz); legal range 2..2^24.
FILT_LEN, 4, consecutive stable cycles required before a filtered input changes; legal range 1..255.

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
enc_a  input  1  raw encoder channel A, asynchronous to clk
enc_b  input  1  raw encoder channel B, asynchronous to clk
clear  input  1  synchronous one-cycle clear request from the register slave
step  output  32  signed position count, two's complement
speed  output  32  signed counts in the last completed gate window
speed_valid  output  1  one-cycle pulse when speed updates
dir  output  1  direction of last valid count: 1 = forward, 0 = reverse
err  output  1  sticky illegal-transition flag

Behaviour:
- Reset: clk is the clock; rst_n is the reset, asynchronous, active-low. While asserted, all of the following are 0:
  - outputs step, speed, speed_valid, dir, err;
  - synchroniser flops, filter counters, filtered A/B, previous-state register, gate counter and window accumulator.
- Reset mid-operation discards any partial window. The first window after release is a full GATE_CYCLES long.
- Synchroniser: two flops per channel.
- Filter, per channel, independent:
  - A counter increments while the sync output differs from the filtered value and resets to 0 when they are equal.
  - The filtered value takes the sync value on the cycle the counter reaches FILT_LEN; the counter then resets.
  - Pulses shorter than FILT_LEN cycles at the sync output are fully suppressed.
- Decoder: compares the registered previous filtered {A,B} with the current filtered {A,B} every cycle.
  - Forward, +1: 00->10->11->01->00.
  - Reverse, -1: 00->01->11->10->00.
  - No change: no action.
  - Both bits changed: illegal. No count, dir unchanged, err set.
  - The previous-state register updates every cycle regardless.
- Latency: step changes exactly FILT_LEN+3 clk edges after the first edge that samples the new pin level (2 sync + FILT_LEN filter + 1 decode/accumulate).
- step:
  - Adds the decoded delta.
  - Wraps modulo 2^32, so 0 - 1 = 32'hFFFF_FFFF and 32'h7FFF_FFFF + 1 = 32'h8000_0000.
  - No saturation.
- dir updates only on a valid count.
- Speed gate:
  - The gate counter runs 0..GATE_CYCLES-1 and wraps.
  - The accumulator adds the decoded delta every cycle.
  - On the terminal cycle: speed <= accumulator + that cycle's delta, accumulator <= 0, speed_valid = 1 for that cycle only.
  - speed holds between updates.
- clear, synchronous, highest priority:
  - step, accumulator, gate counter and err go to 0.
  - speed and dir hold.
  - A count decoded in the same cycle is discarded.
  - No speed_valid is produced in a clear cycle; the gate restarts at 0 on the next cycle.
  - The filter and synchroniser are unaffected.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Forward quadrature, 10 full cycles, each level held 20 clk, FILT_LEN=4 -> step=40, dir=1, err=0. The first increment appears 7 edges after the first A rise is sampled.
- From reset, one reverse transition 00->01 -> step=32'hFFFF_FFFF, dir=0. Then 3 more reverse cycles (12 transitions) -> step=32'hFFFF_FFF3.
- Glitch: A high for 3 clk (<FILT_LEN=4), then low -> step stays 0, err=0. Same pulse held 4 clk -> filtered A changes, step=1.
- Illegal jump: drive {A,B} 00->11 simultaneously -> err=1, step unchanged, dir unchanged. Then a clear pulse -> err=0, step=0.
- Speed: GATE_CYCLES=1000, one forward transition every 100 clk steady state -> speed=10 on each speed_valid pulse, pulse spacing exactly 1000 clk. Reverse at the same rate -> speed=32'hFFFF_FFF6.
- Clear coincident with a decoded count cycle -> step=0, not ±1. Next speed_valid arrives 1001 clk after the clear cycle.
